// File: rtl/frame_line_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_line_sched
// Purpose  : Frame scheduler for the trace/retrace output controller. Stages
//            frame parameters, commits them at frame boundaries and sequences
//            one FIFO-gated output session per frame.
// Revision : 1.0 - initial release
// ============================================================================
module frame_line_sched #(
    parameter int LEN_W      = 16,
    parameter int LINE_W     = 12,
    parameter int SETTLE     = 4,
    parameter int START_HOLD = 4,
    parameter int GAP        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    input  logic              run,
    input  logic [LEN_W-1:0]  fifo_words,
    output logic [LEN_W-1:0]  trace_length,
    output logic [LEN_W-1:0]  retrace_length,
    output logic              update_flag,
    output logic              ready_send,
    output logic              start_send,
    output logic [LINE_W-1:0] line_idx,
    output logic              frame_done,
    output logic              busy,
    output logic              err_underrun,
    output logic              err_cfg
);

    localparam int c_MAX_A   = (SETTLE > START_HOLD) ? SETTLE : START_HOLD;
    localparam int c_MAX_B   = (GAP > 2) ? GAP : 2;
    localparam int c_TMR_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_COMMIT_LAST = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(SETTLE - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST   = c_TMR_W'(START_HOLD - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST    = c_TMR_W'(GAP - 1);
    localparam logic [LEN_W-1:0]   c_MIN_PERIOD  = LEN_W'(4);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMMIT    = 3'd1,
        S_ARM       = 3'd2,
        S_WAIT_FIFO = 3'd3,
        S_START     = 3'd4,
        S_RUN       = 3'd5,
        S_FRAME_END = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TMR_W-1:0]  r_tmr;

    logic [LEN_W-1:0]    r_stg_trace;
    logic [LEN_W-1:0]    r_stg_retrace;
    logic [LINE_W-1:0]   r_stg_lines;
    logic [LEN_W-1:0]    r_stg_period;

    logic [LEN_W-1:0]    r_act_trace;
    logic [LEN_W-1:0]    r_act_retrace;
    logic [LINE_W-1:0]   r_act_lines;
    logic [LEN_W-1:0]    r_act_period;

    logic [LEN_W-1:0]    r_pcnt;
    logic [LINE_W-1:0]   r_line;

    logic                r_update;
    logic                r_ready;
    logic                r_start;
    logic                r_done;
    logic                r_busy;
    logic                r_underrun;

    logic                w_cfg_ok;
    logic                w_fifo_ok;
    logic                w_wrap;
    logic                w_last_line;
    logic                w_entering;
    logic                w_timed;

    assign w_cfg_ok    = (r_stg_trace != '0) && (r_stg_lines != '0) &&
                         (r_stg_period >= c_MIN_PERIOD);
    assign w_fifo_ok   = (fifo_words >= r_act_trace);
    assign w_wrap      = (r_pcnt == (r_act_period - LEN_W'(1)));
    assign w_last_line = (r_line == (r_act_lines - LINE_W'(1)));
    assign w_entering  = (w_state_nxt != r_state);
    assign w_timed     = (r_state == S_COMMIT) || (r_state == S_ARM) ||
                         (r_state == S_START)  || (r_state == S_FRAME_END);

    // Staged registers accept writes in every state; only COMMIT reads them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_trace   <= '0;
            r_stg_retrace <= '0;
            r_stg_lines   <= '0;
            r_stg_period  <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    r_stg_trace   <= LEN_W'(cfg_wdata);
                2'd1:    r_stg_retrace <= LEN_W'(cfg_wdata);
                2'd2:    r_stg_lines   <= LINE_W'(cfg_wdata);
                default: r_stg_period  <= LEN_W'(cfg_wdata);
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run && w_cfg_ok)
                    w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (r_tmr == c_COMMIT_LAST)
                    w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (r_tmr == c_SETTLE_LAST)
                    w_state_nxt = w_fifo_ok ? S_START : S_WAIT_FIFO;
            end
            S_WAIT_FIFO: begin
                if (w_fifo_ok)
                    w_state_nxt = S_START;
            end
            S_START: begin
                // A short frame can finish while start_send is still held.
                if (w_wrap && w_last_line)
                    w_state_nxt = S_FRAME_END;
                else if (r_tmr == c_HOLD_LAST)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_wrap && w_last_line)
                    w_state_nxt = S_FRAME_END;
            end
            S_FRAME_END: begin
                if (r_tmr == c_GAP_LAST)
                    w_state_nxt = (run && w_cfg_ok) ? S_COMMIT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_act_trace   <= '0;
            r_act_retrace <= '0;
            r_act_lines   <= '0;
            r_act_period  <= '0;
            r_pcnt        <= '0;
            r_line        <= '0;
            r_update      <= 1'b0;
            r_ready       <= 1'b0;
            r_start       <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_entering)
                r_tmr <= '0;
            else if (w_timed)
                r_tmr <= r_tmr + c_TMR_W'(1);

            if (w_entering && (w_state_nxt == S_COMMIT)) begin
                r_act_trace   <= r_stg_trace;
                r_act_retrace <= r_stg_retrace;
                r_act_lines   <= r_stg_lines;
                r_act_period  <= r_stg_period;
            end

            // START time belongs to line 0, so counting begins on its first cycle.
            if (w_entering && (w_state_nxt == S_START)) begin
                r_pcnt <= '0;
                r_line <= '0;
            end else if ((r_state == S_START) || (r_state == S_RUN)) begin
                if (w_wrap) begin
                    r_pcnt <= '0;
                    if (!w_last_line)
                        r_line <= r_line + LINE_W'(1);
                end else begin
                    r_pcnt <= r_pcnt + LEN_W'(1);
                end
            end

            if (w_entering && (w_state_nxt == S_COMMIT))
                r_underrun <= 1'b0;
            else if ((r_state == S_RUN) && (fifo_words == '0))
                r_underrun <= 1'b1;

            r_update <= (w_state_nxt == S_COMMIT);
            r_ready  <= (w_state_nxt == S_ARM)   || (w_state_nxt == S_WAIT_FIFO) ||
                        (w_state_nxt == S_START) || (w_state_nxt == S_RUN);
            r_start  <= (w_state_nxt == S_START);
            r_done   <= w_entering && (w_state_nxt == S_FRAME_END);
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign trace_length   = r_act_trace;
    assign retrace_length = r_act_retrace;
    assign update_flag    = r_update;
    assign ready_send     = r_ready;
    assign start_send     = r_start;
    assign line_idx       = r_line;
    assign frame_done     = r_done;
    assign busy           = r_busy;
    assign err_underrun   = r_underrun;
    assign err_cfg        = ~w_cfg_ok;

endmodule
`default_nettype wire

// File: tb/tb_frame_line_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_line_sched
// Purpose  : Self-checking bench for frame_line_sched: step table plus
//            directed sequences for gating, underrun, reset and bad config.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_line_sched;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        run;
    logic [15:0] fifo_words;
    logic [15:0] trace_length;
    logic [15:0] retrace_length;
    logic        update_flag;
    logic        ready_send;
    logic        start_send;
    logic [11:0] line_idx;
    logic        frame_done;
    logic        busy;
    logic        err_underrun;
    logic        err_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    frame_line_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .run            (run),
        .fifo_words     (fifo_words),
        .trace_length   (trace_length),
        .retrace_length (retrace_length),
        .update_flag    (update_flag),
        .ready_send     (ready_send),
        .start_send     (start_send),
        .line_idx       (line_idx),
        .frame_done     (frame_done),
        .busy           (busy),
        .err_underrun   (err_underrun),
        .err_cfg        (err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        run;
        logic [15:0] fifo;
        int          adv;
        logic        upd, rdy, st, done, bsy, und, ecfg;
        logic [11:0] line;
        logic [15:0] tl, rl;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(int we, int addr, int wd, int r, int fifo, int adv,
                                int upd, int rdy, int st, int dn, int bsy, int und,
                                int ecfg, int ln, int tl, int rl);
        vec_t v;
        v.we = 1'(we);   v.addr = 2'(addr); v.wdata = 16'(wd);
        v.run = 1'(r);   v.fifo = 16'(fifo); v.adv = adv;
        v.upd = 1'(upd); v.rdy = 1'(rdy);   v.st = 1'(st);   v.done = 1'(dn);
        v.bsy = 1'(bsy); v.und = 1'(und);   v.ecfg = 1'(ecfg);
        v.line = 12'(ln); v.tl = 16'(tl);   v.rl = 16'(rl);
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return ready_send;
            1:       return start_send;
            default: return frame_done;
        endcase
    endfunction

    task automatic wait_high(input int sel, input int budget, input string name);
        int n = 0;
        while (get_sig(sel) !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        n_checks++;
        if (get_sig(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got low after %0d cycles expected high", name, budget);
        end
    endtask

    task automatic write_cfg(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(addr);
        cfg_wdata = 16'(data);
        step(1);
        cfg_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
        run = 1'b0; fifo_words = 16'd200;

        // Basic frame (trace 100, retrace 20, lines 3, period 50) and a staged
        // trace write during RUN. Each step: apply inputs, advance, check.
        vecs[0]  = mk(0,0,0,  0,200,1,  0,0,0,0,0,0,1, 0,  0, 0);
        vecs[1]  = mk(1,0,100,0,200,1,  0,0,0,0,0,0,1, 0,  0, 0);
        vecs[2]  = mk(1,1,20, 0,200,1,  0,0,0,0,0,0,1, 0,  0, 0);
        vecs[3]  = mk(1,2,3,  0,200,1,  0,0,0,0,0,0,1, 0,  0, 0);
        vecs[4]  = mk(1,3,50, 0,200,1,  0,0,0,0,0,0,0, 0,  0, 0);
        vecs[5]  = mk(0,0,0,  1,200,1,  1,0,0,0,1,0,0, 0,100,20);
        vecs[6]  = mk(0,0,0,  1,200,1,  1,0,0,0,1,0,0, 0,100,20);
        vecs[7]  = mk(0,0,0,  1,200,1,  0,1,0,0,1,0,0, 0,100,20);
        vecs[8]  = mk(0,0,0,  1,200,3,  0,1,0,0,1,0,0, 0,100,20);
        vecs[9]  = mk(0,0,0,  1,200,1,  0,1,1,0,1,0,0, 0,100,20);
        vecs[10] = mk(0,0,0,  1,200,3,  0,1,1,0,1,0,0, 0,100,20);
        vecs[11] = mk(0,0,0,  1,200,1,  0,1,0,0,1,0,0, 0,100,20);
        vecs[12] = mk(0,0,0,  1,200,45, 0,1,0,0,1,0,0, 0,100,20);
        vecs[13] = mk(0,0,0,  1,200,1,  0,1,0,0,1,0,0, 1,100,20);
        vecs[14] = mk(0,0,0,  1,200,50, 0,1,0,0,1,0,0, 2,100,20);
        vecs[15] = mk(1,0,64, 1,200,1,  0,1,0,0,1,0,0, 2,100,20);
        vecs[16] = mk(0,0,0,  1,200,48, 0,1,0,0,1,0,0, 2,100,20);
        vecs[17] = mk(0,0,0,  1,200,1,  0,0,0,1,1,0,0, 2,100,20);
        vecs[18] = mk(0,0,0,  1,200,1,  0,0,0,0,1,0,0, 2,100,20);
        vecs[19] = mk(0,0,0,  1,200,6,  0,0,0,0,1,0,0, 2,100,20);
        vecs[20] = mk(0,0,0,  1,200,1,  1,0,0,0,1,0,0, 2, 64,20);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
            run = vecs[i].run; fifo_words = vecs[i].fifo;
            step(vecs[i].adv);
            chk($sformatf("v%0d.update_flag", i),    32'(update_flag),    32'(vecs[i].upd));
            chk($sformatf("v%0d.ready_send", i),     32'(ready_send),     32'(vecs[i].rdy));
            chk($sformatf("v%0d.start_send", i),     32'(start_send),     32'(vecs[i].st));
            chk($sformatf("v%0d.frame_done", i),     32'(frame_done),     32'(vecs[i].done));
            chk($sformatf("v%0d.busy", i),           32'(busy),           32'(vecs[i].bsy));
            chk($sformatf("v%0d.err_underrun", i),   32'(err_underrun),   32'(vecs[i].und));
            chk($sformatf("v%0d.err_cfg", i),        32'(err_cfg),        32'(vecs[i].ecfg));
            chk($sformatf("v%0d.line_idx", i),       32'(line_idx),       32'(vecs[i].line));
            chk($sformatf("v%0d.trace_length", i),   32'(trace_length),   32'(vecs[i].tl));
            chk($sformatf("v%0d.retrace_length", i), 32'(retrace_length), 32'(vecs[i].rl));
        end
        cfg_we = 1'b0;

        // Underrun for one RUN cycle, then run dropped mid-frame.
        wait_high(1, 20, "underrun.start_seen");
        step(6);
        fifo_words = 16'd0; run = 1'b0;
        step(1);
        chk("underrun.set", 32'(err_underrun), 32'd1);
        fifo_words = 16'd200;
        step(3);
        chk("underrun.sticky", 32'(err_underrun), 32'd1);
        chk("rundrop.still_busy", 32'(busy), 32'd1);
        wait_high(2, 300, "rundrop.frame_done_seen");
        chk("rundrop.ready_low_at_end", 32'(ready_send), 32'd0);
        step(1);
        chk("rundrop.done_one_cycle", 32'(frame_done), 32'd0);
        step(7);
        chk("rundrop.idle_busy", 32'(busy), 32'd0);
        chk("rundrop.idle_ready", 32'(ready_send), 32'd0);
        chk("rundrop.underrun_kept", 32'(err_underrun), 32'd1);
        step(3);
        chk("rundrop.stays_idle", 32'(busy), 32'd0);

        // FIFO gating at exactly trace_length, plus exact frame length.
        write_cfg(0, 100);
        run = 1'b1; fifo_words = 16'd99;
        wait_high(0, 10, "gate.ready_seen");
        chk("gate.underrun_cleared", 32'(err_underrun), 32'd0);
        chk("gate.trace_committed", 32'(trace_length), 32'd100);
        step(20);
        chk("gate.no_start", 32'(start_send), 32'd0);
        chk("gate.ready_held", 32'(ready_send), 32'd1);
        fifo_words = 16'd100;
        step(1);
        chk("gate.start_after_fill", 32'(start_send), 32'd1);
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        chk("gate.frame_len", 32'(n), 32'd150);

        // Asynchronous reset in the middle of RUN.
        wait_high(1, 40, "reset.start_seen");
        step(10);
        reset_n = 1'b0;
        #1;
        chk("reset.ready", 32'(ready_send), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.line", 32'(line_idx), 32'd0);
        chk("reset.trace", 32'(trace_length), 32'd0);
        chk("reset.start", 32'(start_send), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(4);
        chk("reset.err_cfg", 32'(err_cfg), 32'd1);
        chk("reset.stay_idle", 32'(busy), 32'd0);
        chk("reset.no_update", 32'(update_flag), 32'd0);

        // Period 3 is invalid; period 4 with one line is the shortest frame.
        write_cfg(3, 3);
        write_cfg(0, 10);
        write_cfg(1, 5);
        write_cfg(2, 1);
        chk("badcfg.err_cfg", 32'(err_cfg), 32'd1);
        step(3);
        chk("badcfg.busy", 32'(busy), 32'd0);
        chk("badcfg.no_update", 32'(update_flag), 32'd0);
        write_cfg(3, 4);
        chk("mincfg.err_cfg", 32'(err_cfg), 32'd0);
        chk("mincfg.not_yet_busy", 32'(busy), 32'd0);
        step(1);
        chk("mincfg.update1", 32'(update_flag), 32'd1);
        chk("mincfg.trace", 32'(trace_length), 32'd10);
        chk("mincfg.retrace", 32'(retrace_length), 32'd5);
        step(1);
        chk("mincfg.update2", 32'(update_flag), 32'd1);
        step(1);
        chk("mincfg.update_off", 32'(update_flag), 32'd0);
        chk("mincfg.ready_on", 32'(ready_send), 32'd1);
        wait_high(1, 20, "mincfg.start_seen");
        n = 0;
        while (frame_done !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        chk("mincfg.frame_len", 32'(n), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_line_sched.md
# frame_line_sched

Frame-level scheduler for the trace/retrace frame output controller. It holds staged frame parameters written over a simple register port and commits them only at frame boundaries, signalled by an `update_flag` pulse. It drives `ready_send`/`start_send` so one output session runs per frame, gated on FIFO fill, and reports frame completion and underrun.

## Interface
- `LEN_W`, 16: width of trace/retrace lengths, line period and `fifo_words`.
- `LINE_W`, 12: width of the lines-per-frame count and `line_idx`.
- `SETTLE`, 4: cycles `ready_send` is held high before the FIFO check, so the downstream domain can synchronise.
- `START_HOLD`, 4: cycles `start_send` is held high.
- `GAP`, 8: cycles `ready_send` is held low between frames.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  2  register select: 0 = trace_len, 1 = retrace_len, 2 = lines_per_frame, 3 = line_period.
- `cfg_wdata`  in  16  write data. lines_per_frame takes bits [LINE_W-1:0]; the other registers take bits [LEN_W-1:0].
- `run`  in  1  level; frames are produced while high.
- `fifo_words`  in  LEN_W  current output FIFO fill.
- `trace_length`, `retrace_length`  out  LEN_W  committed (active) values.
- `update_flag`  out  1  commit pulse.
- `ready_send`  out  1  output session enable.
- `start_send`  out  1  session start pulse.
- `line_idx`  out  LINE_W  current line within the frame.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_underrun`  out  1  sticky underrun flag.
- `err_cfg`  out  1  combinational: staged configuration is invalid.

## Operation
- **Staged registers:** written on `cfg_we` in any state. Reset values: trace_len = 0, retrace_len = 0, lines = 0, period = 0. Active outputs change only in COMMIT.
- **Config validity:** valid when staged trace_len ≠ 0, lines ≠ 0 and period ≥ 4. `err_cfg` is the inverse of this.
- **States:** IDLE, COMMIT, ARM, WAIT_FIFO, START, RUN, FRAME_END. All outputs are registered and Moore-style.
- **IDLE:** `ready_send` = 0. If `run` = 1 and the config is valid, go to COMMIT. Otherwise stay in IDLE, even if `run` = 1.
- **COMMIT (2 cycles):**
  - Copy staged trace_len, retrace_len, lines and period into the active registers on entry.
  - `update_flag` = 1 for both cycles.
  - Clear `err_underrun`.
  - Then go to ARM.
- **ARM (SETTLE cycles):** `ready_send` = 1, then go to WAIT_FIFO.
- **WAIT_FIFO:** `ready_send` = 1. Hold until `fifo_words` ≥ active trace_length, then go to START. There is no timeout.
- **START (START_HOLD cycles):** `start_send` = 1. Clear the period counter and `line_idx` to 0, then go to RUN.
- **RUN:**
  - The period counter counts 0 .. period-1.
  - At period-1 the counter wraps and `line_idx` increments.
  - At the wrap with `line_idx` = lines-1, go to FRAME_END.
  - The period counter starts counting on the first START cycle, so START time is part of line 0.
- **Underrun:** in any RUN cycle with `fifo_words` = 0, set `err_underrun`. It stays set until the next COMMIT or reset.
- **FRAME_END (GAP cycles):**
  - `ready_send` = 0.
  - `frame_done` = 1 on the first cycle only.
  - On exit: if `run` = 1 and the config is valid, go to COMMIT (new staged values take effect); otherwise go to IDLE.
- **`run` falling mid-frame:** the current frame completes normally, then IDLE.
- **`cfg_we` during a frame:** affects only the next COMMIT.

## Timing
- **Reset values:** all outputs 0. Every state register and counter is cleared asynchronously, including mid-frame.
- **Start-up sequence.** Let `run` be sampled high in IDLE at edge E.
  - `update_flag` is high in cycles E+1 and E+2.
  - New `trace_length`/`retrace_length` are visible from E+1.
  - `ready_send` rises at E+3.
- **First `start_send`:** rises no earlier than E+3+SETTLE, later if WAIT_FIFO stalls.
- **Frame length:** from the first `start_send` cycle to the first FRAME_END cycle is exactly lines×period cycles.
- **Frame-to-frame:** `ready_send` low time between frames = GAP + 2 cycles (the COMMIT cycles).
- **Counter widths:** period counter is LEN_W, line counter is LINE_W. Comparisons use the active values. Neither counter ever wraps past its maximum.

## Test plan
- **Basic frame:** trace = 100, retrace = 20, lines = 3, period = 50, `fifo_words` = 200, `run` = 1.
  - `update_flag` high for 2 cycles.
  - `ready_send` rises 3 cycles after `run`.
  - `start_send` high for 4 cycles, starting 4 cycles after `ready_send` rises.
  - `frame_done` occurs 150 cycles after `start_send` rises.
  - `line_idx` steps 0, 1, 2.
- **FIFO gating:** as above but `fifo_words` = 99.
  - Stays in WAIT_FIFO and `start_send` stays 0.
  - Set `fifo_words` = 100: `start_send` rises 1 cycle later.
- **Staged update:** write trace = 64 during RUN.
  - `trace_length` stays 100 until the next COMMIT, then reads 64 with an `update_flag` pulse.
- **Invalid config:** period = 3, `run` = 1.
  - `err_cfg` = 1, state stays IDLE, `busy` = 0, no `update_flag`.
- **Underrun and run drop:**
  - Force `fifo_words` = 0 for 1 RUN cycle: `err_underrun` goes to 1 and stays.
  - Drop `run` mid-frame: the frame completes, `frame_done` pulses, then IDLE with `ready_send` = 0.
- **Reset mid-RUN:** assert `reset_n` = 0 for 1 cycle.
  - All outputs 0 immediately.
  - After release with `run` = 1: a full new COMMIT sequence, with active lengths reloaded from the staged registers (which were reset to 0, so the config is invalid until rewritten).
